// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 decryptor stages (S-memory init, KSA shuffle,
// PRGA/decrypt).
//   ksa_state_t       : state encoding of the key-scheduling swap stage
//   MEM_DEPTH         : number of S-memory entries
//   KEY_BYTES_DEFAULT : default secret-key length in bytes
//   KEY_W_MAX         : widest supported key (8 bytes)
//   keybyte()         : extracts key byte idx from a left-aligned key
// -----------------------------------------------------------------------------
package rc4_pkg;

   localparam int MEM_DEPTH         = 256;
   localparam int KEY_BYTES_DEFAULT = 3;
   localparam int KEY_W_MAX         = 64;

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      LD_I,
      RD_J,
      LD_J,
      WR_I,
      WR_J,
      DONE
   } ksa_state_t;

   // The key is passed left-aligned in a 64-bit word so byte 0 (the
   // most-significant key byte) always sits at bits 63:56, whatever the
   // actual key length is.
   function automatic logic [7:0] keybyte(input logic [KEY_W_MAX-1:0] key,
                                          input logic [2:0]           idx);
      logic [KEY_W_MAX-1:0] shifted;
      shifted = key << {idx, 3'b000};
      return shifted[KEY_W_MAX-1 -: 8];
   endfunction

endpackage

// File: rtl/ksa_shuffle.sv
// -----------------------------------------------------------------------------
// ksa_shuffle
// RC4 key-scheduling swap stage. Assumes the S-memory already holds s[i]=i.
// For i = 0..2**ADDR_W-1: j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j].
// Each iteration takes six cycles: read s[i], load it, read s[j], load it,
// write s[i], write s[j]. The memory has a one-cycle read latency.
//
// Ports
//   clk                  : system clock, rising edge
//   rst                  : asynchronous active-high reset, aborts a run
//   start_shuffle        : run request, sampled only in IDLE
//   secret_key           : key, byte 0 is the most-significant byte
//   mem_q                : S-memory read data (one cycle after address)
//   address_shuffle      : S-memory address
//   write_data_shuffle   : S-memory write data
//   write_enable_shuffle : S-memory write strobe (only in WR_I / WR_J)
//   finish_shuffle       : one-cycle done pulse
//   busy                 : high from start acceptance until finish
// -----------------------------------------------------------------------------
module ksa_shuffle
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_shuffle,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [DATA_W-1:0]      mem_q,
   output logic [ADDR_W-1:0]      address_shuffle,
   output logic [DATA_W-1:0]      write_data_shuffle,
   output logic                   write_enable_shuffle,
   output logic                   finish_shuffle,
   output logic                   busy
);

   ksa_state_t             state;
   ksa_state_t             state_next;
   logic [ADDR_W-1:0]      i;
   logic [DATA_W-1:0]      j;
   logic [2:0]             kidx;
   logic [DATA_W-1:0]      si;
   logic [DATA_W-1:0]      sj;
   logic [8*KEY_BYTES-1:0] key_reg;

   logic [KEY_W_MAX-1:0]   key_left;
   logic [DATA_W-1:0]      key_byte;
   logic                   last_i;
   logic                   kidx_last;

   assign key_left  = KEY_W_MAX'(key_reg) << (KEY_W_MAX - 8*KEY_BYTES);
   assign key_byte  = DATA_W'(keybyte(key_left, kidx));
   assign last_i    = (i == {ADDR_W{1'b1}});
   // kidx is an explicit wrap counter so non-power-of-2 key lengths work.
   assign kidx_last = (kidx == 3'(KEY_BYTES - 1));

   // ---------------------------------------------------------------- state
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its inputs, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ----------------------------------------------------------- next state
   // NOTE: every combinational output gets a default first; a path that left
   // a variable unassigned would infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_shuffle) state_next = RD_I;
         RD_I:    state_next = LD_I;
         LD_I:    state_next = RD_J;
         RD_J:    state_next = LD_J;
         LD_J:    state_next = WR_I;
         WR_I:    state_next = WR_J;
         WR_J:    state_next = last_i ? DONE : RD_I;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   // NOTE: datapath registers are small and all get a defined reset value, so
   // an aborted run cannot leak a stale j or key into the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i       <= '0;
         j       <= '0;
         kidx    <= '0;
         si      <= '0;
         sj      <= '0;
         key_reg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_shuffle) begin
                  key_reg <= secret_key;
                  i       <= '0;
                  j       <= '0;
                  kidx    <= '0;
               end
            end
            LD_I: begin
               si <= mem_q;
               j  <= j + mem_q + key_byte;   // wraps mod 2**DATA_W
            end
            LD_J: sj <= mem_q;
            WR_J: begin
               if (!last_i) begin
                  i    <= i + ADDR_W'(1);
                  kidx <= kidx_last ? 3'd0 : kidx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      address_shuffle      = '0;
      write_data_shuffle   = '0;
      write_enable_shuffle = 1'b0;
      finish_shuffle       = 1'b0;
      busy                 = 1'b0;
      unique case (state)
         IDLE: ;
         RD_I, LD_I: begin
            address_shuffle = i;
            busy            = 1'b1;
         end
         RD_J, LD_J: begin
            address_shuffle = ADDR_W'(j);
            busy            = 1'b1;
         end
         WR_I: begin
            address_shuffle      = i;
            write_data_shuffle   = sj;
            write_enable_shuffle = 1'b1;
            busy                 = 1'b1;
         end
         WR_J: begin
            address_shuffle      = ADDR_W'(j);
            write_data_shuffle   = si;
            write_enable_shuffle = 1'b1;
            busy                 = 1'b1;
         end
         DONE:    finish_shuffle = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ksa_shuffle.sv
// -----------------------------------------------------------------------------
// tb_ksa_shuffle
// Two DUT builds (KEY_BYTES=3 and KEY_BYTES=5), each attached to a behavioural
// 256x8 S-memory with one-cycle read latency. Expected memory contents and
// write streams come from a software RC4-KSA model.
// -----------------------------------------------------------------------------
module tb_ksa_shuffle;

   localparam int RUN_CYCLES = 1537;
   localparam int BOUND      = 2000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // KEY_BYTES=3 build
   logic        rst3, start3, we3, fin3, busy3, init3;
   logic [23:0] key3;
   logic [7:0]  q3, addr3, wd3;
   logic [7:0]  mem3 [256];
   logic [15:0] wq3 [$];

   // KEY_BYTES=5 build
   logic        rst5, start5, we5, fin5, busy5, init5;
   logic [39:0] key5;
   logic [7:0]  q5, addr5, wd5;
   logic [7:0]  mem5 [256];
   logic [15:0] wq5 [$];

   // software model
   logic [7:0]  model_s [256];
   logic [7:0]  model_a [256];
   logic [15:0] exp_w [$];

   int n_vec = 0;
   int n_bad = 0;

   ksa_shuffle #(.KEY_BYTES(3), .DATA_W(8), .ADDR_W(8)) dut3 (
      .clk(clk), .rst(rst3), .start_shuffle(start3), .secret_key(key3),
      .mem_q(q3), .address_shuffle(addr3), .write_data_shuffle(wd3),
      .write_enable_shuffle(we3), .finish_shuffle(fin3), .busy(busy3)
   );

   ksa_shuffle #(.KEY_BYTES(5), .DATA_W(8), .ADDR_W(8)) dut5 (
      .clk(clk), .rst(rst5), .start_shuffle(start5), .secret_key(key5),
      .mem_q(q5), .address_shuffle(addr5), .write_data_shuffle(wd5),
      .write_enable_shuffle(we5), .finish_shuffle(fin5), .busy(busy5)
   );

   // S-memories: synchronous write, registered read, identity init on request
   always @(posedge clk) begin
      if (init3) for (int k = 0; k < 256; k++) mem3[k] <= 8'(k);
      else if (we3) mem3[addr3] <= wd3;
      q3 <= mem3[addr3];
      if (we3) wq3.push_back({addr3, wd3});
   end

   always @(posedge clk) begin
      if (init5) for (int k = 0; k < 256; k++) mem5[k] <= 8'(k);
      else if (we5) mem5[addr5] <= wd5;
      q5 <= mem5[addr5];
      if (we5) wq5.push_back({addr5, wd5});
   end

   // ------------------------------------------------------------- helpers
   task automatic init_mem3();
      @(negedge clk); init3 = 1'b1;
      @(negedge clk); init3 = 1'b0;
   endtask

   task automatic init_mem5();
      @(negedge clk); init5 = 1'b1;
      @(negedge clk); init5 = 1'b0;
   endtask

   // Textbook RC4 KSA over model_s; key given right-aligned, nb bytes,
   // byte 0 most significant. Also records the expected write stream.
   task automatic model_ksa(input logic [63:0] key, input int nb);
      int jm;
      logic [7:0] t, kb;
      jm = 0;
      exp_w.delete();
      for (int i = 0; i < 256; i++) begin
         kb = 8'(key >> (8 * (nb - 1 - (i % nb))));
         jm = (jm + int'(model_s[i]) + int'(kb)) % 256;
         exp_w.push_back({8'(i), model_s[jm]});
         exp_w.push_back({8'(jm), model_s[i]});
         t = model_s[i]; model_s[i] = model_s[jm]; model_s[jm] = t;
      end
   endtask

   task automatic model_identity();
      for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
   endtask

   function automatic int diff3();
      int d = 0;
      for (int k = 0; k < 256; k++) if (mem3[k] !== model_s[k]) d++;
      return d;
   endfunction

   function automatic int diff5();
      int d = 0;
      for (int k = 0; k < 256; k++) if (mem5[k] !== model_s[k]) d++;
      return d;
   endfunction

   // Start a run on dut3 and wait (bounded) for finish. cycles counts from the
   // start-accept edge; at disturb_at a second start and a new key are driven.
   task automatic run3(input logic [23:0] key, input int disturb_at,
                       output int cycles, output logic busy_at1);
      @(negedge clk); key3 = key; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0; cycles = 1; busy_at1 = busy3;
      while (fin3 !== 1'b1 && cycles < BOUND) begin
         @(negedge clk); cycles++;
         if (cycles == disturb_at) begin start3 = 1'b1; key3 = ~key; end
         else start3 = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst3 = 1'b1; rst5 = 1'b1; start3 = 1'b0; start5 = 1'b0;
      key3 = '0; key5 = '0; init3 = 1'b0; init5 = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (addr3 !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", addr3); end
      n_vec++; if (wd3 !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", wd3); end
      n_vec++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we3); end
      rst3 = 1'b0; rst5 = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (fin3 !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", fin3); end
      n_vec++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy3); end
      n_vec++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL reset_busy5: got %b want 0", busy5); end
   endtask

   task automatic test_basic();
      int cyc, base, d;
      logic b1;
      init_mem3();
      model_identity(); model_ksa(64'h010203, 3);
      base = wq3.size();
      run3(24'h010203, 0, cyc, b1);
      n_vec++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b want 1", b1); end
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL basic_cycles: got %0d want %0d", cyc, RUN_CYCLES); end
      n_vec++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", busy3); end
      n_vec++; if (wq3[base] !== 16'h0001) begin n_bad++; $display("FAIL basic_wr0: got %h want 0001", wq3[base]); end
      n_vec++; if (wq3[base+1] !== 16'h0100) begin n_bad++; $display("FAIL basic_wr1: got %h want 0100", wq3[base+1]); end
      n_vec++; if (wq3.size() - base !== 512) begin n_bad++; $display("FAIL basic_wr_count: got %0d want 512", wq3.size() - base); end
      @(negedge clk);
      n_vec++; if (fin3 !== 1'b0) begin n_bad++; $display("FAIL basic_finish_width: got %b want 0", fin3); end
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL basic_mem: got %0d bad bytes want 0", d); end
   endtask

   task automatic test_zero_key();
      int cyc, base, d;
      logic b1;
      init_mem3();
      model_identity(); model_ksa(64'h0, 3);
      base = wq3.size();
      run3(24'h000000, 0, cyc, b1);
      n_vec++; if (wq3[base] !== 16'h0000) begin n_bad++; $display("FAIL zero_wr0: got %h want 0000", wq3[base]); end
      n_vec++; if (wq3[base+1] !== 16'h0000) begin n_bad++; $display("FAIL zero_wr1: got %h want 0000", wq3[base+1]); end
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL zero_mem: got %0d bad bytes want 0", d); end
   endtask

   task automatic test_key_249();
      int cyc, d, distinct;
      logic b1;
      logic seen [256];
      init_mem3();
      model_identity(); model_ksa(64'h000249, 3);
      run3(24'h000249, 0, cyc, b1);
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL k249_mem: got %0d bad bytes want 0", d); end
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      distinct = 0;
      for (int k = 0; k < 256; k++) begin
         if (!$isunknown(mem3[k]) && !seen[mem3[k]]) begin seen[mem3[k]] = 1'b1; distinct++; end
      end
      n_vec++; if (distinct !== 256) begin n_bad++; $display("FAIL k249_perm: got %0d distinct want 256", distinct); end
   endtask

   task automatic test_reset_mid();
      int cyc, base, d;
      logic b1;
      init_mem3();
      @(negedge clk); key3 = 24'h010203; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      repeat (700) @(negedge clk);   // cycle 701 is a WR_I cycle
      n_vec++; if (we3 !== 1'b1) begin n_bad++; $display("FAIL rmid_we_before: got %b want 1", we3); end
      rst3 = 1'b1;
      #1;
      n_vec++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL rmid_we: got %b want 0", we3); end
      n_vec++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy3); end
      n_vec++; if (addr3 !== 8'h00) begin n_bad++; $display("FAIL rmid_addr: got %h want 00", addr3); end
      base = wq3.size();
      repeat (3) @(negedge clk);
      n_vec++; if (wq3.size() !== base) begin n_bad++; $display("FAIL rmid_no_writes: got %0d want %0d", wq3.size(), base); end
      rst3 = 1'b0;
      init_mem3();
      model_identity(); model_ksa(64'h010203, 3);
      run3(24'h010203, 0, cyc, b1);
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL rmid_cycles: got %0d want %0d", cyc, RUN_CYCLES); end
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL rmid_mem: got %0d bad bytes want 0", d); end
   endtask

   task automatic test_busy_restart();
      int cyc, d;
      logic b1;
      init_mem3();
      model_identity(); model_ksa(64'h0A0B0C, 3);
      run3(24'h0A0B0C, 300, cyc, b1);
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL busy_cycles: got %0d want %0d", cyc, RUN_CYCLES); end
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL busy_mem: got %0d bad bytes want 0", d); end
   endtask

   task automatic test_back_to_back();
      int cyc, d;
      init_mem3();
      model_identity(); model_ksa(64'h1F2E3D, 3);
      model_a = model_s;
      @(negedge clk); key3 = 24'h1F2E3D; start3 = 1'b1;
      @(negedge clk); cyc = 1;
      while (fin3 !== 1'b1 && cyc < BOUND) begin @(negedge clk); cyc++; end
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL b2b_cycles1: got %0d want %0d", cyc, RUN_CYCLES); end
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL b2b_mem1: got %0d bad bytes want 0", d); end
      @(negedge clk);   // IDLE with start still high
      n_vec++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy3); end
      @(negedge clk);   // first cycle of the second run
      n_vec++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy3); end
      start3 = 1'b0; cyc = 1;
      while (fin3 !== 1'b1 && cyc < BOUND) begin @(negedge clk); cyc++; end
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL b2b_cycles2: got %0d want %0d", cyc, RUN_CYCLES); end
      model_s = model_a; model_ksa(64'h1F2E3D, 3);
      d = diff3();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL b2b_mem2: got %0d bad bytes want 0", d); end
   endtask

   task automatic test_kb5();
      int cyc, base, d;
      init_mem5();
      model_identity(); model_ksa(64'h0102030405, 5);
      base = wq5.size();
      @(negedge clk); key5 = 40'h0102030405; start5 = 1'b1;
      @(negedge clk); start5 = 1'b0; cyc = 1;
      while (fin5 !== 1'b1 && cyc < BOUND) begin @(negedge clk); cyc++; end
      n_vec++; if (cyc !== RUN_CYCLES) begin n_bad++; $display("FAIL kb5_cycles: got %0d want %0d", cyc, RUN_CYCLES); end
      // iterations 0..5 use key bytes 0,1,2,3,4,0
      for (int n = 0; n < 12; n++) begin
         n_vec++;
         if (wq5[base+n] !== exp_w[n]) begin
            n_bad++; $display("FAIL kb5_wr%0d: got %h want %h", n, wq5[base+n], exp_w[n]);
         end
      end
      d = diff5();
      n_vec++; if (d !== 0) begin n_bad++; $display("FAIL kb5_mem: got %0d bad bytes want 0", d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_key();
      test_key_249();
      test_reset_mid();
      test_busy_restart();
      test_back_to_back();
      test_kb5();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
